dbus_initiator: RTL and testbench
=================================

# dbus_initiator

Single-outstanding data-bus initiator for the peripheral subsystem; it is the requesting end of the dbus that peripheral register blocks (gpio, uart, timer) respond to. It accepts read/write commands on a valid/ready command port, drives the dbus request until the addressed peripheral acks, and returns read data and an error flag on a valid/ready response port. A programmable timeout frees the bus when an unmapped or hung peripheral never acks.

## Interface
- TIMEOUT_CYCLES, 16: maximum cycles `req` stays high without `ack` before the transaction aborts; 0 disables the timeout.
- ERR_CNT_W, 8: width of the saturating error counter.
- clk  in  1  single clock; all logic on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- cmd_valid_i  in  1  command present.
- cmd_ready_o  out  1  initiator can accept a command.
- cmd_we_i  in  1  1 = write, 0 = read.
- cmd_addr_i  in  32  peripheral byte address.
- cmd_wdata_i  in  32  write data; ignored for reads.
- dbus2peri_o  out  type_dbus2peri_s  fields `req`, `w_en`, `addr`, `w_data` driven to the peripheral decoder.
- peri2dbus_i  in  type_peri2dbus_s  fields `ack`, `r_data` from the selected peripheral.
- rsp_valid_o  out  1  response present.
- rsp_ready_i  in  1  consumer accepts the response.
- rsp_rdata_o  out  32  read data; 0 for writes and for errored transactions.
- rsp_err_o  out  1  transaction timed out.
- err_cnt_o  out  ERR_CNT_W  count of timed-out transactions, saturating at all-ones.

## Operation
- FSM states: IDLE, REQ, RESP.
- IDLE:
  - `cmd_ready_o` = 1.
  - On `cmd_valid_i`, capture `we`, `addr` and `wdata` (wdata forced to 0 for reads), clear the timeout counter, and go to REQ.
- REQ:
  - `dbus2peri_o.req` = 1; `w_en`, `addr` and `w_data` come from the captured registers and are held stable for the whole state.
  - The timeout counter increments every cycle.
  - `ack` = 1: capture `r_data` (reads only; writes capture 0), set err = 0, go to RESP.
  - Else, if TIMEOUT_CYCLES ≠ 0 and the counter equals TIMEOUT_CYCLES − 1: set rdata = 0, err = 1, increment `err_cnt` (saturating), go to RESP.
  - If `ack` and timeout occur in the same cycle, `ack` wins: no error.
- RESP:
  - `rsp_valid_o` = 1; rdata and err are held stable.
  - On `rsp_ready_i`, go to IDLE.
- `ack` seen in IDLE or RESP (a late ack after a timeout) is ignored and never corrupts a held response.
- `req` is a decode of state == REQ. It therefore deasserts the cycle after `ack` is sampled, which prevents the responder from starting a second access.
- `cmd_ready_o` is 0 in REQ and RESP, so only one transaction is ever outstanding.
- In IDLE and RESP, `dbus2peri_o` fields are 0 except `addr` and `w_data`, which may hold their last value.

## Timing
- Reset (asynchronous, immediate):
  - state = IDLE, `cmd_ready_o` = 1, `rsp_valid_o` = 0, `rsp_rdata_o` = 0, `rsp_err_o` = 0, `err_cnt_o` = 0.
  - All `dbus2peri_o` fields = 0.
  - Reset mid-transaction drops `req` immediately and discards the transaction; no response is produced.
- Command handshake in cycle C: `req` = 1 in cycles C+1 onward.
- With a registered-ack peripheral (ack one cycle after req): ack in C+2, `req` = 0 in C+3, `rsp_valid_o` = 1 in C+3.
- Timeout with TIMEOUT_CYCLES = N: `req` is high for exactly N cycles (C+1 … C+N), and `rsp_valid_o` rises at C+N+1 with err = 1.
- Response accepted in cycle R: `cmd_ready_o` = 1 in R+1. Back-to-back throughput is one transaction per 4 cycles with a 1-cycle-ack peripheral and `rsp_ready_i` tied high.
- `rsp_valid_o` held with `rsp_ready_i` = 0 for any length: outputs stay constant.
- `cmd_valid_i` with `cmd_ready_o` = 0: the command is not consumed; the source holds it.

## Test plan
- Write then read: write addr 0x04 data 0x000000A5 to a model with 1-cycle ack, then read 0x04.
  - Each transaction: `req` high exactly 2 cycles, `w_en` = 1 then 0.
  - Write response: rdata 0, err 0.
  - Read response: rdata 0x000000A5, err 0.
- Timeout: read 0x80 with the model never acking, TIMEOUT_CYCLES = 16.
  - `req` high exactly 16 cycles.
  - Response: rdata 0, err 1; `err_cnt_o` 0 → 1.
- Late ack and tie: the model acks 1 cycle after the timeout.
  - Held response is unchanged (err 1, rdata 0).
  - With ack on exactly the 16th `req` cycle: err 0 and data captured.
- Response backpressure: hold `rsp_ready_i` low 10 cycles while `cmd_valid_i` stays high.
  - `rsp_*` stable and `cmd_ready_o` 0 throughout.
  - Next command is accepted the cycle after `rsp_ready_i` rises.
- Reset mid-REQ: assert `rst` during the 2nd `req` cycle.
  - `req` and `rsp_valid_o` go to 0 asynchronously; `cmd_ready_o` = 1.
  - No response is produced after reset release.
- Error saturation: with ERR_CNT_W = 2, issue 5 timed-out reads → `err_cnt_o` reads 1, 2, 3, 3, 3.

Source files
------------

// File: rtl/dbus_initiator.sv
// Single-outstanding dbus initiator: command port in, dbus request out, response port back.
// A programmable timeout aborts requests that a peripheral never acks.
package dbus_pkg;
  typedef struct packed {
    logic        req;
    logic        w_en;
    logic [31:0] addr;
    logic [31:0] w_data;
  } type_dbus2peri_s;

  typedef struct packed {
    logic        ack;
    logic [31:0] r_data;
  } type_peri2dbus_s;
endpackage

module dbus_initiator
  import dbus_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned ERR_CNT_W      = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid_i,
  output logic                 cmd_ready_o,
  input  logic                 cmd_we_i,
  input  logic [31:0]          cmd_addr_i,
  input  logic [31:0]          cmd_wdata_i,
  output type_dbus2peri_s      dbus2peri_o,
  input  type_peri2dbus_s      peri2dbus_i,
  output logic                 rsp_valid_o,
  input  logic                 rsp_ready_i,
  output logic [31:0]          rsp_rdata_o,
  output logic                 rsp_err_o,
  output logic [ERR_CNT_W-1:0] err_cnt_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t                 state_r, state_nxt_s;
  logic                   we_r, we_nxt_s;
  logic [31:0]            addr_r, addr_nxt_s;
  logic [31:0]            wdata_r, wdata_nxt_s;
  logic [31:0]            tmo_cnt_r, tmo_cnt_nxt_s;
  logic [31:0]            rdata_r, rdata_nxt_s;
  logic                   err_r, err_nxt_s;
  logic [ERR_CNT_W-1:0]   err_cnt_r, err_cnt_nxt_s;
  logic                   req_r, w_en_r, cmd_ready_r, rsp_valid_r;
  logic                   tmo_hit_s;

  function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
    if (v == {ERR_CNT_W{1'b1}}) begin
      sat_inc = v;
    end else begin
      sat_inc = v + ERR_CNT_W'(1);
    end
  endfunction

  // A zero TIMEOUT_CYCLES disables the abort path entirely.
  assign tmo_hit_s = (TIMEOUT_CYCLES != 32'd0) && (tmo_cnt_r == (TIMEOUT_CYCLES - 32'd1));

  // Next-state and next-register values for the transaction FSM.
  always_comb begin
    state_nxt_s   = state_r;
    we_nxt_s      = we_r;
    addr_nxt_s    = addr_r;
    wdata_nxt_s   = wdata_r;
    tmo_cnt_nxt_s = tmo_cnt_r;
    rdata_nxt_s   = rdata_r;
    err_nxt_s     = err_r;
    err_cnt_nxt_s = err_cnt_r;
    case (state_r)
      IDLE: begin
        if (cmd_valid_i) begin
          state_nxt_s   = REQ;
          we_nxt_s      = cmd_we_i;
          addr_nxt_s    = cmd_addr_i;
          wdata_nxt_s   = cmd_we_i ? cmd_wdata_i : 32'd0;
          tmo_cnt_nxt_s = 32'd0;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      REQ: begin
        tmo_cnt_nxt_s = tmo_cnt_r + 32'd1;
        // ack takes priority over a timeout landing in the same cycle
        if (peri2dbus_i.ack) begin
          state_nxt_s = RESP;
          rdata_nxt_s = we_r ? 32'd0 : peri2dbus_i.r_data;
          err_nxt_s   = 1'b0;
        end else if (tmo_hit_s) begin
          state_nxt_s   = RESP;
          rdata_nxt_s   = 32'd0;
          err_nxt_s     = 1'b1;
          err_cnt_nxt_s = sat_inc(err_cnt_r);
        end else begin
          state_nxt_s = REQ;
        end
      end
      RESP: begin
        if (rsp_ready_i) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = RESP;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State, captured transaction and registered decode of the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      we_r        <= 1'b0;
      addr_r      <= 32'd0;
      wdata_r     <= 32'd0;
      tmo_cnt_r   <= 32'd0;
      rdata_r     <= 32'd0;
      err_r       <= 1'b0;
      err_cnt_r   <= '0;
      req_r       <= 1'b0;
      w_en_r      <= 1'b0;
      cmd_ready_r <= 1'b1;
      rsp_valid_r <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      we_r        <= we_nxt_s;
      addr_r      <= addr_nxt_s;
      wdata_r     <= wdata_nxt_s;
      tmo_cnt_r   <= tmo_cnt_nxt_s;
      rdata_r     <= rdata_nxt_s;
      err_r       <= err_nxt_s;
      err_cnt_r   <= err_cnt_nxt_s;
      req_r       <= (state_nxt_s == REQ);
      w_en_r      <= (state_nxt_s == REQ) && we_nxt_s;
      cmd_ready_r <= (state_nxt_s == IDLE);
      rsp_valid_r <= (state_nxt_s == RESP);
    end
  end

  assign dbus2peri_o.req    = req_r;
  assign dbus2peri_o.w_en   = w_en_r;
  assign dbus2peri_o.addr   = addr_r;
  assign dbus2peri_o.w_data = wdata_r;
  assign cmd_ready_o        = cmd_ready_r;
  assign rsp_valid_o        = rsp_valid_r;
  assign rsp_rdata_o        = rdata_r;
  assign rsp_err_o          = err_r;
  assign err_cnt_o          = err_cnt_r;

endmodule

// File: tb/tb_dbus_initiator.sv
// Bench for dbus_initiator: directed vector table, hand sequences for reset and saturation,
// then randomized transactions checked against a transaction-level model.
module tb_dbus_initiator;
  import dbus_pkg::*;

  localparam int unsigned TMO = 16;
  localparam int unsigned ECW = 2;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            cmd_valid = 1'b0;
  logic            cmd_ready;
  logic            cmd_we = 1'b0;
  logic [31:0]     cmd_addr = 32'd0;
  logic [31:0]     cmd_wdata = 32'd0;
  type_dbus2peri_s dbus;
  type_peri2dbus_s peri;
  logic            rsp_valid;
  logic            rsp_ready = 1'b0;
  logic [31:0]     rsp_rdata;
  logic            rsp_err;
  logic [ECW-1:0]  err_cnt;

  dbus_initiator #(.TIMEOUT_CYCLES(TMO), .ERR_CNT_W(ECW)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_we_i(cmd_we),
    .cmd_addr_i(cmd_addr), .cmd_wdata_i(cmd_wdata),
    .dbus2peri_o(dbus), .peri2dbus_i(peri),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata),
    .rsp_err_o(rsp_err), .err_cnt_o(err_cnt)
  );

  always #5 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  int unsigned cyc = 0;
  logic [31:0] mem [64];
  logic [31:0] ref_mem [64];
  int lat_cur = 0;
  bit late_cur = 1'b0;
  int req_cyc = 0;
  bit prev_req = 1'b0;
  int err_model = 0;

  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          lat;
    bit          late;
    int          delay;
    bit          hold;
    logic [31:0] exp_rdata;
    bit          exp_err;
    int          exp_req;
  } vec_t;

  vec_t vt [11];
  int sat_exp [5] = '{1, 2, 3, 3, 3};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock; afterwards the peripheral model drives ack/r_data for the new cycle.
  // lat_cur = n acks in the n-th req cycle (0 = never); late_cur acks once right after req drops.
  task automatic tick();
    if (peri.ack && dbus.req && dbus.w_en) mem[dbus.addr[7:2]] = dbus.w_data;
    @(posedge clk);
    #1;
    cyc++;
    if (dbus.req) begin
      req_cyc++;
      peri.ack = (lat_cur != 0) && (req_cyc == lat_cur);
    end else begin
      req_cyc = 0;
      peri.ack = late_cur && prev_req;
    end
    peri.r_data = (peri.ack && dbus.req && !dbus.w_en) ? mem[dbus.addr[7:2]] : $urandom;
    prev_req = dbus.req;
  endtask

  task automatic do_txn(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                        input int lat, input bit late, input int delay, input bit hold,
                        input logic [31:0] exp_rdata, input bit exp_err, input int exp_req);
    int waits = 0;
    int rc = 0;
    bit bad;
    lat_cur = lat;
    late_cur = late;
    cmd_we = we;
    cmd_addr = addr;
    cmd_wdata = wdata;
    cmd_valid = 1'b1;
    while (!cmd_ready && waits < 50) begin
      tick();
      waits++;
    end
    check("accept_wait", waits, 0);
    tick();
    if (!hold) cmd_valid = 1'b0;
    check("req_rise", dbus.req, 1);
    bad = 1'b0;
    while (dbus.req && rc < 100) begin
      if (dbus.w_en !== we || dbus.addr !== addr || dbus.w_data !== (we ? wdata : 32'd0) ||
          cmd_ready !== 1'b0 || rsp_valid !== 1'b0) bad = 1'b1;
      rc++;
      tick();
    end
    check("req_fields", bad, 0);
    check("req_cycles", rc, exp_req);
    if (exp_err && err_model < 3) err_model++;
    if (we && !exp_err) ref_mem[addr[7:2]] = wdata;
    check("rsp_valid", rsp_valid, 1);
    check("rsp_rdata", rsp_rdata, exp_rdata);
    check("rsp_err", rsp_err, exp_err);
    check("err_cnt", err_cnt, err_model);
    bad = 1'b0;
    for (int i = 0; i < delay; i++) begin
      tick();
      if (rsp_valid !== 1'b1 || rsp_rdata !== exp_rdata || rsp_err !== exp_err ||
          err_cnt !== ECW'(err_model) || cmd_ready !== 1'b0 || dbus.req !== 1'b0 ||
          dbus.w_en !== 1'b0) bad = 1'b1;
    end
    if (delay > 0) check("rsp_hold", bad, 0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("idle_after_rsp", {rsp_valid, cmd_ready}, 2'b01);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned c0;
    bit bad;
    bit we;
    bit ok;
    int lat;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;

    peri.ack = 1'b0;
    peri.r_data = 32'd0;
    for (int i = 0; i < 64; i++) begin
      mem[i] = 32'd0;
      ref_mem[i] = 32'd0;
    end

    vt[0]  = '{1'b1, 32'h04, 32'h000000A5, 2,  1'b0, 0,  1'b0, 32'h0,        1'b0, 2};
    vt[1]  = '{1'b0, 32'h04, 32'h0,        2,  1'b0, 1,  1'b0, 32'h000000A5, 1'b0, 2};
    vt[2]  = '{1'b0, 32'h80, 32'h0,        0,  1'b0, 0,  1'b0, 32'h0,        1'b1, 16};
    vt[3]  = '{1'b0, 32'h04, 32'h0,        0,  1'b1, 3,  1'b0, 32'h0,        1'b1, 16};
    vt[4]  = '{1'b0, 32'h04, 32'h0,        16, 1'b0, 0,  1'b0, 32'h000000A5, 1'b0, 16};
    vt[5]  = '{1'b1, 32'h08, 32'h12345678, 1,  1'b0, 0,  1'b0, 32'h0,        1'b0, 1};
    vt[6]  = '{1'b0, 32'h08, 32'h0,        3,  1'b0, 10, 1'b1, 32'h12345678, 1'b0, 3};
    vt[7]  = '{1'b0, 32'h04, 32'h0,        2,  1'b0, 0,  1'b0, 32'h000000A5, 1'b0, 2};
    vt[8]  = '{1'b1, 32'h04, 32'hDEADBEEF, 0,  1'b0, 2,  1'b0, 32'h0,        1'b1, 16};
    vt[9]  = '{1'b0, 32'h04, 32'h0,        17, 1'b0, 0,  1'b0, 32'h0,        1'b1, 16};
    vt[10] = '{1'b0, 32'h04, 32'h0,        2,  1'b0, 0,  1'b0, 32'h000000A5, 1'b0, 2};

    // asynchronous reset, checked before any clock edge
    #1 rst = 1'b1;
    #2;
    check("reset_cmd_ready", cmd_ready, 1);
    check("reset_rsp", {rsp_valid, rsp_err, rsp_rdata}, 34'd0);
    check("reset_err_cnt", err_cnt, 0);
    check("reset_dbus", dbus, 66'd0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    tick();

    for (int i = 0; i < 11; i++) begin
      do_txn(vt[i].we, vt[i].addr, vt[i].wdata, vt[i].lat, vt[i].late, vt[i].delay,
             vt[i].hold, vt[i].exp_rdata, vt[i].exp_err, vt[i].exp_req);
    end

    // back-to-back throughput with a registered-ack peripheral
    c0 = cyc;
    for (int i = 0; i < 3; i++) begin
      do_txn(1'b0, 32'h04, 32'h0, 2, 1'b0, 0, 1'b0, 32'h000000A5, 1'b0, 2);
    end
    check("throughput_cycles", cyc - c0, 12);

    // reset during the second req cycle
    lat_cur = 5;
    late_cur = 1'b0;
    cmd_we = 1'b0;
    cmd_addr = 32'h04;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    check("rst_mid_req_rise", dbus.req, 1);
    tick();
    #2 rst = 1'b1;
    #1;
    check("rst_mid_async", {dbus.req, rsp_valid, cmd_ready}, 3'b001);
    check("rst_mid_err_cnt", err_cnt, 0);
    err_model = 0;
    #1 rst = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (rsp_valid !== 1'b0 || dbus.req !== 1'b0 || cmd_ready !== 1'b1) bad = 1'b1;
    end
    check("rst_no_response", bad, 0);

    // error counter saturation
    for (int i = 0; i < 5; i++) begin
      do_txn(1'b0, 32'h80, 32'h0, 0, 1'b0, 0, 1'b0, 32'h0, 1'b1, 16);
      check("err_sat_seq", err_cnt, sat_exp[i]);
    end

    // randomized transactions against the transaction-level model
    for (int i = 0; i < 30; i++) begin
      we = 1'($urandom_range(0, 1));
      addr = {24'd0, 6'($urandom_range(0, 63)), 2'b00};
      wdata = $urandom;
      lat = int'($urandom_range(0, 20));
      ok = (lat != 0) && (lat <= int'(TMO));
      exp_rd = (ok && !we) ? ref_mem[addr[7:2]] : 32'd0;
      do_txn(we, addr, wdata, lat, ($urandom_range(0, 3) == 0), int'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)), exp_rd, !ok, ok ? lat : int'(TMO));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
